// File: rtl/fadd_norm_seq.sv
// fadd_norm_seq: normalization stage of the FP add/sub datapath.
// Normalizes the raw 49-bit magnitude sum. It either takes one right step on
// a carry-out or shifts left by at most SHIFT_STEP positions per cycle. The
// normalized exponent, fraction, GRS field and flags are then presented to
// the rounding stage through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// SHIFT | normalizing mant/exp, one step per cycle
// DONE  | result held on outputs until out_ready
module fadd_norm_seq #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [48:0] mant_sum,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    input  logic        nan_in,
    input  logic        inf1_in,
    input  logic        inf2_in,
    input  logic        sign1_in,
    input  logic        sign2_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_norm,
    output logic [22:0] mantissa_norm,
    output logic [23:0] grs,
    output logic        sign_res,
    output logic        underflow,
    output logic        NaN,
    output logic        inf1,
    output logic        inf2,
    output logic        sign1,
    output logic        sign2
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [48:0] mant_q, mant_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        uf_q, uf_d;
    logic [4:0]  flag_q, flag_d;   // {nan, inf1, inf2, sign1, sign2}

    logic [3:0]  lz;
    logic        special;
    logic        mant_zero;
    logic        need_shift;

    // Leading-zero count over the top SHIFT_STEP bits below the carry position
    always_comb begin
        lz = 4'(SHIFT_STEP);
        for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
            if (mant_q[47 - i]) lz = 4'(i);
        end
    end

    // SHIFT-state decode: special flags and zero sum take priority over shifting
    always_comb begin
        special    = flag_q[4] | flag_q[3] | flag_q[2];
        mant_zero  = (mant_q == '0);
        need_shift = !special && !mant_zero && !mant_q[48] && !mant_q[47]
                     && (exp_q > {4'b0, lz});
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (!need_shift) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is also masked while reset is held
    always_comb begin
        in_ready  = (state_q == IDLE) && reset_n;
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load in IDLE, one normalization step in SHIFT
    always_comb begin
        mant_d = mant_q;
        exp_d  = exp_q;
        sign_d = sign_q;
        uf_d   = uf_q;
        flag_d = flag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d = mant_sum;
                    exp_d  = exp_in;
                    sign_d = sign_in;
                    uf_d   = 1'b0;
                    flag_d = {nan_in, inf1_in, inf2_in, sign1_in, sign2_in};
                end
            end
            SHIFT: begin
                if (special) begin
                    // pass through untouched
                end else if (mant_zero) begin
                    uf_d   = 1'b1;
                    sign_d = flag_q[1] & flag_q[0];
                end else if (mant_q[48]) begin
                    // right step keeps the dropped bit as sticky
                    mant_d = {1'b0, mant_q[48:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 8'd1;
                end else if (mant_q[47]) begin
                    // already normalized
                end else if (exp_q <= {4'b0, lz}) begin
                    // flush to zero; subnormals are not produced
                    uf_d = 1'b1;
                end else begin
                    mant_d = mant_q << lz;
                    exp_d  = exp_q - {4'b0, lz};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mant_q <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            uf_q   <= 1'b0;
            flag_q <= '0;
        end else begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            sign_q <= sign_d;
            uf_q   <= uf_d;
            flag_q <= flag_d;
        end
    end

    assign exp_norm      = exp_q;
    assign mantissa_norm = mant_q[46:24];
    assign grs           = mant_q[23:0];
    assign sign_res      = sign_q;
    assign underflow     = uf_q;
    assign NaN           = flag_q[4];
    assign inf1          = flag_q[3];
    assign inf2          = flag_q[2];
    assign sign1         = flag_q[1];
    assign sign2         = flag_q[0];

endmodule

// File: tb/tb_fadd_norm_seq.sv
// tb_fadd_norm_seq: directed vectors for the FP add normalization stage.
module tb_fadd_norm_seq;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] mant_sum;
    logic [7:0]  exp_in;
    logic        sign_in, nan_in, inf1_in, inf2_in, sign1_in, sign2_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_norm;
    logic [22:0] mantissa_norm;
    logic [23:0] grs;
    logic        sign_res, underflow, NaN, inf1, inf2, sign1, sign2;

    int total = 0;
    int bad   = 0;

    fadd_norm_seq #(.SHIFT_STEP(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mant_sum(mant_sum), .exp_in(exp_in), .sign_in(sign_in),
        .nan_in(nan_in), .inf1_in(inf1_in), .inf2_in(inf2_in),
        .sign1_in(sign1_in), .sign2_in(sign2_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_norm(exp_norm), .mantissa_norm(mantissa_norm), .grs(grs),
        .sign_res(sign_res), .underflow(underflow), .NaN(NaN),
        .inf1(inf1), .inf2(inf2), .sign1(sign1), .sign2(sign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [48:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic [4:0]  fl;      // {nan, inf1, inf2, sign1, sign2}
        logic [7:0]  e_exp;
        logic [22:0] e_mn;
        logic [23:0] e_grs;
        logic        e_sign;
        logic        e_uf;
        int          e_lat;   // edges from acceptance until out_valid
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Drives one operation, waits for the result, checks it, optionally
    // holds out_ready low for `hold` cycles, then consumes it.
    task automatic run_vec(input int i, input int hold);
        int cyc;
        bit got;
        @(negedge clk);
        chk($sformatf("v%0d in_ready_idle", i), 64'(in_ready), 64'd1);
        mant_sum = vec[i].mant;
        exp_in   = vec[i].exp;
        sign_in  = vec[i].sign;
        {nan_in, inf1_in, inf2_in, sign1_in, sign2_in} = vec[i].fl;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk($sformatf("v%0d in_ready_busy", i), 64'(in_ready), 64'd0);
        cyc = 0;
        got = 0;
        while (!got && cyc < 60) begin
            if (cyc > 0) @(posedge clk);
            else         #0;
            if (cyc > 0) #1;
            else begin
                @(posedge clk);
                #1;
            end
            cyc++;
            if (out_valid) got = 1;
        end
        chk($sformatf("v%0d latency", i), 64'(cyc), 64'(vec[i].e_lat));
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d hold_valid", i), 64'(out_valid), 64'd1);
                chk($sformatf("v%0d hold_in_ready", i), 64'(in_ready), 64'd0);
            end
            chk($sformatf("v%0d exp_norm", i), 64'(exp_norm), 64'(vec[i].e_exp));
            chk($sformatf("v%0d mantissa_norm", i), 64'(mantissa_norm), 64'(vec[i].e_mn));
            chk($sformatf("v%0d grs", i), 64'(grs), 64'(vec[i].e_grs));
            chk($sformatf("v%0d sign_res", i), 64'(sign_res), 64'(vec[i].e_sign));
            chk($sformatf("v%0d underflow", i), 64'(underflow), 64'(vec[i].e_uf));
            chk($sformatf("v%0d flags", i), 64'({NaN, inf1, inf2, sign1, sign2}), 64'(vec[i].fl));
            if (hold > 0) begin
                // upstream tries to push while busy; must be ignored
                in_valid = 1'b1;
                mant_sum = 49'h1_2345_6789_ABCD;
                exp_in   = 8'd77;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk($sformatf("v%0d consumed_valid", i), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d consumed_ready", i), 64'(in_ready), 64'd1);
    endtask

    initial begin
        //          mant                                              exp     s     fl         e_exp   e_mn          e_grs         s     uf    lat
        vec[0]  = '{49'h1 << 48,                                     8'd127, 1'b0, 5'b00000, 8'd128, 23'h0,        24'h0,        1'b0, 1'b0, 1};
        vec[1]  = '{49'h1 << 46,                                     8'd127, 1'b0, 5'b00000, 8'd126, 23'h0,        24'h0,        1'b0, 1'b0, 2};
        vec[2]  = '{49'h1,                                           8'd127, 1'b1, 5'b00000, 8'd80,  23'h0,        24'h0,        1'b1, 1'b0, 13};
        vec[3]  = '{(49'h1 << 48) | 49'h1,                           8'd100, 1'b0, 5'b00000, 8'd101, 23'h0,        24'h000001,   1'b0, 1'b0, 1};
        vec[4]  = '{49'h1 << 40,                                     8'd3,   1'b0, 5'b00000, 8'd3,   23'h010000,   24'h0,        1'b0, 1'b1, 1};
        vec[5]  = '{49'h0,                                           8'd50,  1'b1, 5'b00001, 8'd50,  23'h0,        24'h0,        1'b0, 1'b1, 1};
        vec[6]  = '{(49'h1 << 47) | (49'h2AAAAA << 24) | 49'hABCDEF, 8'd10,  1'b1, 5'b00011, 8'd10,  23'h2AAAAA,   24'hABCDEF,   1'b1, 1'b0, 1};
        vec[7]  = '{49'h5,                                           8'd255, 1'b0, 5'b10000, 8'd255, 23'h0,        24'h000005,   1'b0, 1'b0, 1};
        vec[8]  = '{(49'h1 << 41) | (49'h1 << 20),                   8'd20,  1'b0, 5'b00000, 8'd14,  23'h000004,   24'h0,        1'b0, 1'b0, 3};
        vec[9]  = '{49'h1 << 41,                                     8'd6,   1'b0, 5'b00000, 8'd2,   23'h200000,   24'h0,        1'b0, 1'b1, 2};
        vec[10] = '{49'h3 << 47,                                     8'd254, 1'b0, 5'b00000, 8'd255, 23'h400000,   24'h0,        1'b0, 1'b0, 1};
        vec[11] = '{49'h0,                                           8'd255, 1'b1, 5'b01010, 8'd255, 23'h0,        24'h0,        1'b1, 1'b0, 1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_sum  = '0;
        exp_in    = '0;
        {sign_in, nan_in, inf1_in, inf2_in, sign1_in, sign2_in} = '0;

        #12;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst data", 64'({exp_norm, mantissa_norm, grs} != '0), 64'd0);
        chk("rst flags", 64'({sign_res, underflow, NaN, inf1, inf2, sign1, sign2}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < NV; i++) run_vec(i, 0);

        // backpressure: result must stay put for 5 cycles with out_ready low
        run_vec(8, 5);

        // reset during SHIFT discards the deep-shift operation
        @(negedge clk);
        mant_sum = vec[2].mant;
        exp_in   = vec[2].exp;
        sign_in  = 1'b1;
        {nan_in, inf1_in, inf2_in, sign1_in, sign2_in} = 5'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd0);
        chk("midrst exp_norm", 64'(exp_norm), 64'd0);
        chk("midrst sign_res", 64'(sign_res), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("midrst released in_ready", 64'(in_ready), 64'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("midrst discarded out_valid", 64'(out_valid), 64'd0);
        chk("midrst idle in_ready", 64'(in_ready), 64'd1);

        run_vec(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
